// File: rtl/compare_pkg.sv
// compare_pkg
// Shared types and constants for the compare_stream_nbit block.
//   cmp_result_t : one-hot compare result, bit order {gt, eq, lt}
//   CMP_GT/EQ/LT : the three legal result codes
package compare_pkg;

    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t CMP_GT = 3'b100;
    localparam cmp_result_t CMP_EQ = 3'b010;
    localparam cmp_result_t CMP_LT = 3'b001;

endpackage

// File: rtl/compare_core.sv
// compare_core
// Purely combinational magnitude comparator producing a one-hot result.
// Ports:
//   a, b        : operands (WIDTH bits)
//   signed_mode : 1 = two's-complement compare, 0 = unsigned
//   result      : CMP_GT / CMP_EQ / CMP_LT
module compare_core
    import compare_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_result_t      result
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned magnitude compare serves both modes.
    logic [WIDTH-1:0] a_ord;
    logic [WIDTH-1:0] b_ord;

    assign a_ord = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    assign b_ord = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};

    always_comb begin
        result = CMP_LT;
        if (a == b) begin
            result = CMP_EQ;
        end else if (a_ord > b_ord) begin
            result = CMP_GT;
        end
    end

endmodule

// File: rtl/compare_stream_nbit.sv
// compare_stream_nbit
// Streaming comparator with a single output register, saturating result
// statistics and running min/max of accepted 'a' operands.
// Optional feature macro: CMP_SIGNED_EN (adds signed_mode port; without it
// every compare is unsigned).
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : operand handshake for a, b (and signed_mode)
//   a, b                    : operands, CMP_WIDTH bits
//   signed_mode             : 1 = signed compare (CMP_SIGNED_EN builds only)
//   clear                   : sync clear of counters and min/max trackers
//   out_valid / out_ready   : result handshake
//   greater, equal, smaller : registered one-hot result
//   gt/eq/lt_count          : saturating counts of delivered results
//   max_a, min_a            : running max/min of accepted a
module compare_stream_nbit
    import compare_pkg::*;
#(
    parameter int CMP_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMP_WIDTH-1:0] a,
    input  logic [CMP_WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic                 signed_mode,
`endif
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 greater,
    output logic                 equal,
    output logic                 smaller,
    output logic [CNT_WIDTH-1:0] gt_count,
    output logic [CNT_WIDTH-1:0] eq_count,
    output logic [CNT_WIDTH-1:0] lt_count,
    output logic [CMP_WIDTH-1:0] max_a,
    output logic [CMP_WIDTH-1:0] min_a
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic        mode;
    logic        accept;
    logic        deliver;
    logic        first_pending;
    cmp_result_t res_ab;
    cmp_result_t res_max;
    cmp_result_t res_min;

`ifdef CMP_SIGNED_EN
    assign mode = signed_mode;
`else
    assign mode = 1'b0;
`endif

    // Output register may be refilled in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    compare_core #(.WIDTH(CMP_WIDTH)) u_cmp_ab (
        .a           (a),
        .b           (b),
        .signed_mode (mode),
        .result      (res_ab)
    );

    compare_core #(.WIDTH(CMP_WIDTH)) u_cmp_max (
        .a           (a),
        .b           (max_a),
        .signed_mode (mode),
        .result      (res_max)
    );

    compare_core #(.WIDTH(CMP_WIDTH)) u_cmp_min (
        .a           (a),
        .b           (min_a),
        .signed_mode (mode),
        .result      (res_min)
    );

    // Result register; result bits hold their last values after draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            greater   <= 1'b0;
            equal     <= 1'b0;
            smaller   <= 1'b0;
        end else if (accept) begin
            out_valid                  <= 1'b1;
            {greater, equal, smaller}  <= res_ab;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Delivery statistics; a delivery in a clear cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_count <= '0;
            eq_count <= '0;
            lt_count <= '0;
        end else if (clear) begin
            gt_count <= '0;
            eq_count <= '0;
            lt_count <= '0;
        end else if (deliver) begin
            if (greater && gt_count != CNT_MAX) gt_count <= gt_count + CNT_ONE;
            if (equal   && eq_count != CNT_MAX) eq_count <= eq_count + CNT_ONE;
            if (smaller && lt_count != CNT_MAX) lt_count <= lt_count + CNT_ONE;
        end
    end

    // Min/max trackers. The first accept after reset or clear seeds both;
    // an accept in the clear cycle counts as that first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_a         <= '0;
            min_a         <= '0;
            first_pending <= 1'b1;
        end else if (accept && (first_pending || clear)) begin
            max_a         <= a;
            min_a         <= a;
            first_pending <= 1'b0;
        end else if (clear) begin
            max_a         <= '0;
            min_a         <= '0;
            first_pending <= 1'b1;
        end else if (accept) begin
            if (res_max == CMP_GT) max_a <= a;
            if (res_min == CMP_LT) min_a <= a;
        end
    end

endmodule

// File: doc/compare_stream_nbit.md
COMPARE_STREAM_NBIT -- requirements
Module: compare_stream_nbit

Interface
REQ-001 Parameter CMP_WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 Parameter CNT_WIDTH, default 8: width of each result-statistics counter, legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair a/b present.
REQ-006 in_ready  output  1  block accepts a/b this cycle.
REQ-007 a, b  input  CMP_WIDTH  operands.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands (only when CMP_SIGNED_EN is defined).
REQ-009 clear  input  1  synchronous clear of counters and min/max trackers.
REQ-010 out_valid  output  1  registered result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 greater, equal, smaller  output  1 each  registered one-hot compare result.
REQ-013 gt_count, eq_count, lt_count  output  CNT_WIDTH each  saturating totals of delivered results.
REQ-014 max_a, min_a  output  CMP_WIDTH each  running maximum/minimum of accepted a values, in the active compare mode.

Function
REQ-015 The transfer "accept" SHALL be in_valid && in_ready; in_ready = !out_valid || out_ready (single-register pipeline, no combinational path from in_valid to out_valid).
REQ-016 On accept, greater/equal/smaller SHALL be loaded with (a>b, a==b, a<b) and out_valid set to 1 at the next edge: latency exactly 1 cycle.
REQ-017 Exactly one of greater/equal/smaller SHALL be 1 whenever out_valid=1.
REQ-018 When out_valid && out_ready with no accept, out_valid SHALL clear to 0; result bits hold their last values.
REQ-019 When out_valid && !out_ready, out_valid and result bits SHALL hold unchanged (back-pressure, no loss, no duplication).
REQ-020 Each result SHALL increment exactly one counter on the cycle it is delivered (out_valid && out_ready); a counter at all-ones SHALL stay at all-ones.
REQ-021 max_a/min_a SHALL update on accept; the first accept after reset or clear loads both with a.
REQ-022 clear SHALL zero all counters and re-arm the first-sample load on the next edge; it does not affect out_valid or result bits. A delivery coinciding with clear is not counted; an accept coinciding with clear loads max_a=min_a=a.
REQ-023 Simultaneous delivery and accept in one cycle SHALL sustain throughput of one result per clock.

Reset
REQ-024 rst_n low SHALL asynchronously force out_valid=0, greater=equal=smaller=0, all counters=0, max_a=min_a=0, first-sample flag armed.
REQ-025 Reset asserted mid-transfer SHALL discard the held result; in_ready SHALL be 1 from the first edge after reset release.

Configuration
REQ-026 Macro CMP_SIGNED_EN: when defined, the signed_mode port exists and selects signed/unsigned compare for the result and the min/max trackers.
REQ-027 When CMP_SIGNED_EN is undefined, the signed_mode port is absent and all comparisons are unsigned.

Structure
REQ-028 Package compare_pkg SHALL hold typedef cmp_result_t (3-bit {gt,eq,lt}) and localparams CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
REQ-029 Sub-module compare_core SHALL be the purely combinational comparator (a, b, signed_mode -> cmp_result_t), instanced once for a-vs-b and used by the min/max trackers through separate instances.

Verification (CMP_WIDTH=4, CNT_WIDTH=2)
REQ-030 a=9,b=3, out_ready=1, unsigned -> next cycle greater=1, out_valid=1; following cycle gt_count=1.
REQ-031 With CMP_SIGNED_EN: a=4'b1001,b=4'b0011, signed_mode=1 -> smaller=1; same operands with signed_mode=0 -> greater=1.
REQ-032 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, result held, then released in order, no counts lost.
REQ-033 Five equal pairs delivered -> eq_count saturates at 3; then clear -> all counters 0.
REQ-034 Stream a=5,2,7,2 -> max_a=7, min_a=2; rst_n pulsed low mid-stream -> immediate out_valid=0, max_a=min_a=0.
